// File: rtl/interleaver_rd_if.sv
// Output bit-stream handshake of the interleaver read side.
// The master drives data and framing and the slave drives ready.
interface interleaver_rd_if;
    logic out_data;
    logic out_valid;
    logic out_start;
    logic out_end;
    logic out_ready;

    modport master (output out_data, out_valid, out_start, out_end, input out_ready);
    modport slave  (input out_data, out_valid, out_start, out_end, output out_ready);
endinterface

// File: rtl/interleaver_rd_fsm.sv
// Read-side controller for the interleaver ping-pong RAMs. It reads a full bank in QPP order
// and streams the bits out through a small skid FIFO that hides the 1-cycle RAM read latency.
module interleaver_rd_fsm #(
    parameter int AW = 13,
    parameter int FD = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          block_size,
    input  logic          ram1_full,
    input  logic          ram2_full,
    input  logic          ram1_q,
    input  logic          ram2_q,
    output logic          ram1_re,
    output logic          ram2_re,
    output logic [AW-1:0] rd_addr,
    output logic          ram1_release,
    output logic          ram2_release,
    output logic          overflow,
    interleaver_rd_if.master os
);
    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    // Per-size constants: K, the initial increment (f1+f2) mod K, and the second difference 2*f2 mod K
    localparam logic [AW-1:0] K0 = AW'(1056);
    localparam logic [AW-1:0] K1 = AW'(6144);
    localparam logic [AW-1:0] G0 = AW'(83);
    localparam logic [AW-1:0] G1 = AW'(743);
    localparam logic [AW-1:0] D0 = AW'(132);
    localparam logic [AW-1:0] D1 = AW'(960);

    logic [1:0]    state;
    logic [1:0]    full;
    logic [1:0]    size;
    logic          act;
    logic          big;
    logic [AW-1:0] i_cnt;
    logic [AW-1:0] pi;
    logic [AW-1:0] g;
    logic          inflight;
    logic          infl_start;
    logic          infl_end;

    logic [2:0]    mem [FD];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] count;

    logic [AW-1:0] kk;
    logic [AW-1:0] dd;
    logic [AW:0]   pi_sum;
    logic [AW:0]   pi_sub;
    logic [AW:0]   g_sum;
    logic [AW:0]   g_sub;
    logic [AW-1:0] pi_nxt;
    logic [AW-1:0] g_nxt;
    logic [CW:0]   occ;
    logic          pop;
    logic          credit;
    logic          issue;
    logic          last;
    logic          rd_bit;

    assign kk = big ? K1 : K0;
    assign dd = big ? D1 : D0;

    // Operands are both < K, so a single conditional subtract keeps the result in [0,K)
    assign pi_sum = {1'b0, pi} + {1'b0, g};
    assign pi_sub = pi_sum - {1'b0, kk};
    assign pi_nxt = (pi_sum >= {1'b0, kk}) ? pi_sub[AW-1:0] : pi_sum[AW-1:0];
    assign g_sum  = {1'b0, g} + {1'b0, dd};
    assign g_sub  = g_sum - {1'b0, kk};
    assign g_nxt  = (g_sum >= {1'b0, kk}) ? g_sub[AW-1:0] : g_sum[AW-1:0];

    assign pop    = os.out_valid & os.out_ready;
    assign occ    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign credit = occ < (CW+1)'(FD);
    assign issue  = (state == S_READ) && credit;
    assign last   = (i_cnt == kk - AW'(1));

    assign ram1_re      = issue & ~act;
    assign ram2_re      = issue & act;
    assign rd_addr      = pi;
    assign ram1_release = (state == S_REL) & ~act;
    assign ram2_release = (state == S_REL) & act;

    always_ff @(posedge clk) begin
        if (reset) begin
            full     <= '0;
            size     <= '0;
            overflow <= 1'b0;
        end else begin
            if (state == S_REL)
                full[act] <= 1'b0;
            if (ram1_full) begin
                if (full[0]) overflow <= 1'b1;
                else begin
                    full[0] <= 1'b1;
                    size[0] <= block_size;
                end
            end
            if (ram2_full) begin
                if (full[1]) overflow <= 1'b1;
                else begin
                    full[1] <= 1'b1;
                    size[1] <= block_size;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            act        <= 1'b0;
            big        <= 1'b0;
            i_cnt      <= '0;
            pi         <= '0;
            g          <= '0;
            inflight   <= 1'b0;
            infl_start <= 1'b0;
            infl_end   <= 1'b0;
        end else begin
            inflight <= issue;
            case (state)
                S_IDLE: begin
                    if (full[act]) begin
                        state <= S_READ;
                        i_cnt <= '0;
                        pi    <= '0;
                        big   <= size[act];
                        g     <= size[act] ? G1 : G0;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        pi         <= pi_nxt;
                        g          <= g_nxt;
                        i_cnt      <= i_cnt + AW'(1);
                        infl_start <= (i_cnt == '0);
                        infl_end   <= last;
                        if (last) state <= S_REL;
                    end
                end
                S_REL: begin
                    act   <= ~act;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The bank select is still valid for the in-flight read: act toggles only at the end of RELEASE
    assign rd_bit = act ? ram2_q : ram1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (inflight) begin
                mem[wp] <= {rd_bit, infl_start, infl_end};
                wp      <= (wp == PW'(FD - 1)) ? '0 : wp + PW'(1);
            end
            if (pop)
                rp <= (rp == PW'(FD - 1)) ? '0 : rp + PW'(1);
            count <= count + CW'(inflight) - CW'(pop);
        end
    end

    assign os.out_valid = (count != '0);
    assign os.out_data  = os.out_valid & mem[rp][2];
    assign os.out_start = os.out_valid & mem[rp][1];
    assign os.out_end   = os.out_valid & mem[rp][0];
endmodule

// File: tb/tb_interleaver_rd_fsm.sv
// Randomized bench for interleaver_rd_fsm: RAM contents come from $urandom and the expected
// address and bit streams come from the closed-form QPP formula.
module tb_interleaver_rd_fsm;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          block_size = 1'b0;
    logic          ram1_full = 1'b0;
    logic          ram2_full = 1'b0;
    logic          ram1_q = 1'b0;
    logic          ram2_q = 1'b0;
    logic          ram1_re, ram2_re, ram1_release, ram2_release, overflow;
    logic [AW-1:0] rd_addr;

    interleaver_rd_if os();

    interleaver_rd_fsm #(.AW(AW), .FD(2)) dut (
        .clk(clk), .reset(reset), .block_size(block_size),
        .ram1_full(ram1_full), .ram2_full(ram2_full),
        .ram1_q(ram1_q), .ram2_q(ram2_q),
        .ram1_re(ram1_re), .ram2_re(ram2_re), .rd_addr(rd_addr),
        .ram1_release(ram1_release), .ram2_release(ram2_release),
        .overflow(overflow), .os(os)
    );

    always #5 clk = ~clk;

    bit mem1 [8192];
    bit mem2 [8192];

    always @(posedge clk) begin
        if (ram1_re) ram1_q <= mem1[rd_addr];
        if (ram2_re) ram2_q <= mem2[rd_addr];
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint act_v, input longint exp_v);
        n_chk++;
        if (act_v == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act_v, exp_v);
    endtask

    function automatic int qpp(input int k, input int i);
        longint f1 = (k == 1056) ? 17 : 263;
        longint f2 = (k == 1056) ? 66 : 480;
        longint ii = i;
        return int'((f1 * ii + f2 * ii * ii) % k);
    endfunction

    int         exp_a1[$];
    int         exp_a2[$];
    logic [2:0] exp_o[$];
    int         iss_cnt, pop_cnt, blk_iss, distinct2, gap2;
    longint     cyc, last_fin_cyc;
    bit         rel_exp1, rel_exp2, rand_ready;
    bit         seen2 [8192];
    int         first4 [4];

    initial begin
        os.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            os.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: addresses, credit, release timing and the output stream
    always @(negedge clk) begin : mon
        bit fin1, fin2, pop_now;
        int a;
        cyc++;
        fin1 = 0; fin2 = 0;
        pop_now = os.out_valid & os.out_ready;
        if (reset) begin
            exp_a1.delete(); exp_a2.delete(); exp_o.delete();
            iss_cnt = 0; pop_cnt = 0; blk_iss = 0;
            rel_exp1 = 0; rel_exp2 = 0;
        end else begin
            if (ram1_re || ram2_re) begin
                chk("re_excl", ram1_re & ram2_re, 0);
                chk("credit", ((iss_cnt - pop_cnt - int'(pop_now)) < 2), 1);
                if (blk_iss < 4) first4[blk_iss] = int'(rd_addr);
                if (blk_iss == 0 && ram2_re) gap2 = int'(cyc - last_fin_cyc);
                if (ram1_re) begin
                    if (exp_a1.size() > 0) begin
                        a = exp_a1.pop_front();
                        chk("addr1", rd_addr, a);
                        fin1 = (exp_a1.size() == 0);
                    end else chk("spur_re1", ram1_re, 0);
                end
                if (ram2_re) begin
                    if (exp_a2.size() > 0) begin
                        a = exp_a2.pop_front();
                        chk("addr2", rd_addr, a);
                        if (!seen2[rd_addr]) distinct2++;
                        seen2[rd_addr] = 1;
                        fin2 = (exp_a2.size() == 0);
                    end else chk("spur_re2", ram2_re, 0);
                end
                blk_iss++;
                if (fin1 || fin2) begin
                    blk_iss = 0;
                    last_fin_cyc = cyc;
                end
                iss_cnt++;
            end
            if (ram1_release || rel_exp1) chk("rel1", ram1_release, rel_exp1);
            if (ram2_release || rel_exp2) chk("rel2", ram2_release, rel_exp2);
            rel_exp1 = fin1;
            rel_exp2 = fin2;
            if (pop_now) begin
                if (exp_o.size() > 0) chk("out", {os.out_data, os.out_start, os.out_end}, exp_o.pop_front());
                else chk("spur_out", os.out_valid, 0);
                pop_cnt++;
            end
        end
    end

    task automatic load(input int bank, input bit bs, input bit refill);
        int k = bs ? 6144 : 1056;
        if (refill)
            for (int j = 0; j < 8192; j++) begin
                if (bank == 1) mem1[j] = 1'($urandom_range(0, 1));
                else           mem2[j] = 1'($urandom_range(0, 1));
            end
        if (bank == 2) begin
            for (int j = 0; j < 8192; j++) seen2[j] = 0;
            distinct2 = 0;
        end
        for (int j = 0; j < k; j++) begin
            int a = qpp(k, j);
            bit d = (bank == 1) ? mem1[a] : mem2[a];
            if (bank == 1) exp_a1.push_back(a); else exp_a2.push_back(a);
            exp_o.push_back({d, j == 0, j == k - 1});
        end
    endtask

    task automatic pulse(input bit p1, input bit p2, input bit bs);
        @(posedge clk); #1;
        ram1_full = p1; ram2_full = p2; block_size = bs;
        @(posedge clk); #1;
        ram1_full = 0; ram2_full = 0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_o.size() > 0 || exp_a1.size() > 0 || exp_a2.size() > 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_left"}, exp_o.size() + exp_a1.size() + exp_a2.size(), 0);
        repeat (4) @(posedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_re1"}, ram1_re, 0);
        chk({tag, "_re2"}, ram2_re, 0);
        chk({tag, "_addr"}, rd_addr, 0);
        chk({tag, "_rel1"}, ram1_release, 0);
        chk({tag, "_rel2"}, ram2_release, 0);
        chk({tag, "_valid"}, os.out_valid, 0);
        chk({tag, "_data"}, os.out_data, 0);
        chk({tag, "_start"}, os.out_start, 0);
        chk({tag, "_end"}, os.out_end, 0);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk_idle(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, n;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk_idle("rst");

        // K=1056 block on RAM1
        load(1, 0, 1);
        p0 = pop_cnt;
        pulse(1, 0, 0);
        drain("s1", 4000);
        chk("s1_nout", pop_cnt - p0, 1056);
        chk("s1_a0", first4[0], 0);
        chk("s1_a1", first4[1], 83);
        chk("s1_a2", first4[2], 298);
        chk("s1_a3", first4[3], 645);
        chk("s1_ovf", overflow, 0);

        // K=6144 block on RAM2
        load(2, 1, 1);
        p0 = pop_cnt;
        pulse(0, 1, 1);
        drain("s2", 10000);
        chk("s2_nout", pop_cnt - p0, 6144);
        chk("s2_distinct", distinct2, 6144);
        chk("s2_a1", first4[1], 743);
        chk("s2_a2", first4[2], 2446);

        // Same RAM1 contents replayed under random backpressure
        load(1, 0, 0);
        p0 = pop_cnt;
        rand_ready = 1;
        pulse(1, 0, 0);
        drain("s3", 8000);
        rand_ready = 0;
        chk("s3_nout", pop_cnt - p0, 1056);

        // Both banks flagged in one cycle: RAM1 first, then RAM2 after a 2-cycle gap
        do_reset("rst4");
        load(1, 0, 1);
        load(2, 0, 1);
        p0 = pop_cnt;
        gap2 = -1;
        pulse(1, 1, 0);
        drain("s4", 6000);
        chk("s4_nout", pop_cnt - p0, 2112);
        chk("s4_gap", gap2, 3);

        // Duplicate full pulse on a busy bank
        load(1, 0, 1);
        p0 = pop_cnt;
        pulse(1, 0, 0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("s5_ovf_pre", overflow, 0);
        pulse(1, 0, 0);
        @(negedge clk);
        chk("s5_ovf_set", overflow, 1);
        drain("s5", 4000);
        chk("s5_nout", pop_cnt - p0, 1056);
        chk("s5_ovf_hold", overflow, 1);

        // Reset in the middle of a block, then a clean restart
        do_reset("rst6");
        load(1, 0, 1);
        pulse(1, 0, 0);
        n = 0;
        while (blk_iss < 500 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("s6_reach500", blk_iss >= 500, 1);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk_idle("s6");
        repeat (5) @(negedge clk);
        chk("s6_norel1", ram1_release, 0);
        load(1, 0, 1);
        p0 = pop_cnt;
        pulse(1, 0, 0);
        drain("s6b", 4000);
        chk("s6_nout", pop_cnt - p0, 1056);
        chk("s6_a0", first4[0], 0);
        chk("s6_a1", first4[1], 83);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
